sprite_pixel_pipeline: RTL and testbench



---
 rtl/sprite_pixel_pipeline.sv | 216 +++++++++++++++++++++
 tb/tb_sprite_pixel_pipeline.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_pipeline.sv
// -----------------------------------------------------------------------------
// sprite_pixel_pipeline
//
// Purpose:
//   This block sits after the entity detector. For every scan pixel it takes
//   the 9-bit entity word {row[2:0], id[3:0], orient[1:0]} and works out which
//   sprite column the pixel falls in, inside a 40-pixel upscaled tile. It
//   applies the orientation transform and looks the pixel up in the sprite
//   ROM. The result is one registered sprite pixel, with hit and valid flags,
//   and it goes to the colour/VGA stage.
//   Input-to-output latency is exactly two clock edges. The pipeline never
//   stalls.
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-low reset
//   pixel_en     in   1   pixel strobe; counter_H advances by 1 per strobe
//   entity_in    in   9   {row[8:6], id[5:2], orient[1:0]}; 9'h1FF = no entity
//   counter_H    in  10   horizontal scan position (same cycle as entity_in)
//   counter_V    in  10   vertical scan position (same cycle as entity_in)
//   pixel_out    out  1   sprite pixel lit
//   sprite_hit   out  1   an entity (id != 4'hF) covers this pixel
//   pixel_valid  out  1   outputs belong to an active-area pixel
//   hit_count    out 16   lit pixels in the previous frame (optional, see below)
//
// Optional feature:
//   Define SPRITE_HIT_COUNT_EN to add the hit_count output and a saturating
//   per-frame counter of lit pixels. The counter rolls over on the strobe
//   with counter_V == 480 and counter_H == 0.
//
// Sprite ROM:
//   ID 0 is solid and ID 1 is the two leftmost columns. ID 15 is empty.
//   The artwork for IDs 2-14 is in the case table in rom_row().
// -----------------------------------------------------------------------------
module sprite_pixel_pipeline #(
    parameter int UPSCALE_FACTOR  = 5,
    parameter int TILE_SIZE       = 8,
    parameter int SCREEN_H_PIXELS = 640,
    parameter int SCREEN_V_PIXELS = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_en,
    input  logic [8:0]  entity_in,
    input  logic [9:0]  counter_H,
    input  logic [9:0]  counter_V,
    output logic        pixel_out,
    output logic        sprite_hit,
    output logic        pixel_valid
`ifdef SPRITE_HIT_COUNT_EN
    ,
    output logic [15:0] hit_count
`endif
);

    localparam logic [9:0] LP_H_ACTIVE = 10'(SCREEN_H_PIXELS);
    localparam logic [9:0] LP_H_LAST   = 10'(SCREEN_H_PIXELS - 1);
    localparam logic [9:0] LP_V_ACTIVE = 10'(SCREEN_V_PIXELS);
    localparam logic [2:0] LP_SUB_LAST = 3'(UPSCALE_FACTOR - 1);
    localparam logic [2:0] LP_COL_LAST = 3'(TILE_SIZE - 1);
    localparam logic [3:0] LP_ID_NONE  = 4'hF;

    // Each 64-bit word holds 8 rows. Row 0 is the top byte, and bit 7 of each
    // row is the leftmost pixel.
    function automatic logic [7:0] rom_row(input logic [3:0] id, input logic [2:0] r);
        logic [63:0] art;
        case (id)
            4'h0:    art = {8{8'hFF}};
            4'h1:    art = {8{8'hC0}};
            4'h2:    art = 64'h183C_7EFF_1818_1818;
            4'h3:    art = 64'h3C42_A581_A599_423C;
            4'h4:    art = 64'h8142_2418_1824_4281;
            4'h5:    art = 64'h1818_18FF_FF18_1818;
            4'h6:    art = 64'hFF81_8181_8181_81FF;
            4'h7:    art = 64'h0F0F_0F0F_F0F0_F0F0;
            4'h8:    art = 64'hAA55_AA55_AA55_AA55;
            4'h9:    art = 64'h3C7E_FFFF_FFFF_7E3C;
            4'hA:    art = 64'h1038_7CFE_7C38_1000;
            4'hB:    art = 64'h80C0_E0F0_F8FC_FEFF;
            4'hC:    art = 64'h0102_0408_1020_4080;
            4'hD:    art = 64'h7E81_A581_81BD_817E;
            4'hE:    art = 64'hE7E7_E700_0000_E7E7;
            default: art = 64'h0;
        endcase
        return art[{3'(3'd7 - r), 3'b000} +: 8];
    endfunction

    // Column tracker. It always describes the pixel currently on counter_H.
    logic [2:0] r_sub;
    logic [2:0] r_col;

    // Stage 1 registers
    logic [8:0] r_ent;
    logic [2:0] r_col_s1;
    logic       r_act;

    // Stage 2 registers, which drive the outputs
    logic       r_pix;
    logic       r_hit;
    logic       r_valid;

    logic       w_active;
    logic [3:0] w_id;
    logic [2:0] w_row;
    logic [1:0] w_orient;
    logic [2:0] w_row_sel;
    logic [2:0] w_bit_sel;
    logic [7:0] w_rom_bits;
    logic       w_lit;
    logic       w_hit;

    assign w_active = pixel_en && (counter_H < LP_H_ACTIVE) && (counter_V < LP_V_ACTIVE);

    assign w_row    = r_ent[8:6];
    assign w_id     = r_ent[5:2];
    assign w_orient = r_ent[1:0];

    // The orientation selects which ROM row is read and which bit of it is
    // used. A transpose swaps the roles of the sprite row and the column.
    always_comb begin
        // NOTE: every always_comb output gets a default before the case, so
        // no path leaves it unassigned and no latch is inferred.
        w_row_sel = w_row;
        w_bit_sel = 3'(3'd7 - r_col_s1);
        case (w_orient)
            2'b00: begin
                w_row_sel = w_row;
                w_bit_sel = 3'(3'd7 - r_col_s1);
            end
            2'b10: begin
                w_row_sel = w_row;
                w_bit_sel = r_col_s1;
            end
            2'b01: begin
                w_row_sel = r_col_s1;
                w_bit_sel = 3'(3'd7 - w_row);
            end
            default: begin
                w_row_sel = 3'(3'd7 - r_col_s1);
                w_bit_sel = w_row;
            end
        endcase
    end

    assign w_rom_bits = rom_row(w_id, w_row_sel);
    assign w_hit      = (w_id != LP_ID_NONE);
    assign w_lit      = w_hit && w_rom_bits[w_bit_sel];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every register
        // then samples pre-edge values, so the stages shift together.
        if (!reset) begin
            r_sub    <= '0;
            r_col    <= '0;
            r_ent    <= '0;
            r_col_s1 <= '0;
            r_act    <= 1'b0;
            r_pix    <= 1'b0;
            r_hit    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            // Counting sub-pixels avoids a divide by 5. The end-of-line
            // reload realigns the tracker once per line.
            if (pixel_en) begin
                if (counter_H >= LP_H_LAST) begin
                    r_sub <= '0;
                    r_col <= '0;
                end else if (r_sub == LP_SUB_LAST) begin
                    r_sub <= '0;
                    r_col <= (r_col == LP_COL_LAST) ? 3'd0 : 3'(r_col + 3'd1);
                end else begin
                    r_sub <= 3'(r_sub + 3'd1);
                end
            end

            r_ent    <= entity_in;
            r_col_s1 <= r_col;
            r_act    <= w_active;

            r_pix    <= w_lit & r_act;
            r_hit    <= w_hit & r_act;
            r_valid  <= r_act;
        end
    end

    assign pixel_out   = r_pix;
    assign sprite_hit  = r_hit;
    assign pixel_valid = r_valid;

`ifdef SPRITE_HIT_COUNT_EN
    logic [15:0] r_acc;
    logic [15:0] r_hit_count;
    logic        w_pix_next;
    logic        w_frame_end;

    assign w_pix_next  = w_lit & r_act;
    assign w_frame_end = pixel_en && (counter_V == LP_V_ACTIVE) && (counter_H == 10'd0);

    // A lit pixel registered on the frame-end edge is counted in the new
    // frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc       <= '0;
            r_hit_count <= '0;
        end else if (w_frame_end) begin
            r_hit_count <= r_acc;
            r_acc       <= {15'd0, w_pix_next};
        end else if (w_pix_next && (r_acc != 16'hFFFF)) begin
            r_acc <= 16'(r_acc + 16'd1);
        end
    end

    assign hit_count = r_hit_count;
`endif

endmodule

// File: tb/tb_sprite_pixel_pipeline.sv
// -----------------------------------------------------------------------------
// tb_sprite_pixel_pipeline
//
// This bench drives the pipeline with directed and randomized scan lines.
// Each output is compared with a reference model that works straight from
// the pixel-address rules. For an active pixel the column is (H % 40) / 5.
// Orientation picks the ROM row and the bit, and the result appears two
// edges after the input is sampled.
// After a mid-line reset the lit/hit outputs are don't-care until the
// tracker passes the end-of-line point. pixel_valid is checked throughout.
// -----------------------------------------------------------------------------
module tb_sprite_pixel_pipeline;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixel_en;
    logic [8:0] entity_in;
    logic [9:0] counter_H;
    logic [9:0] counter_V;
    logic       pixel_out;
    logic       sprite_hit;
    logic       pixel_valid;
`ifdef SPRITE_HIT_COUNT_EN
    logic [15:0] hit_count;
`endif

    sprite_pixel_pipeline dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_en    (pixel_en),
        .entity_in   (entity_in),
        .counter_H   (counter_H),
        .counter_V   (counter_V),
        .pixel_out   (pixel_out),
        .sprite_hit  (sprite_hit),
        .pixel_valid (pixel_valid)
`ifdef SPRITE_HIT_COUNT_EN
        ,
        .hit_count   (hit_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pix;
        logic hit;
        logic valid;
        bit   care;   // lit/hit are meaningful (tracker aligned)
    } exp_t;

    // Sprite artwork: row 0 in the top byte, bit 7 = leftmost pixel
    logic [63:0] art [16] = '{
        {8{8'hFF}}, {8{8'hC0}},
        64'h183C_7EFF_1818_1818, 64'h3C42_A581_A599_423C,
        64'h8142_2418_1824_4281, 64'h1818_18FF_FF18_1818,
        64'hFF81_8181_8181_81FF, 64'h0F0F_0F0F_F0F0_F0F0,
        64'hAA55_AA55_AA55_AA55, 64'h3C7E_FFFF_FFFF_7E3C,
        64'h1038_7CFE_7C38_1000, 64'h80C0_E0F0_F8FC_FEFF,
        64'h0102_0408_1020_4080, 64'h7E81_A581_81BD_817E,
        64'hE7E7_E700_0000_E7E7, 64'h0
    };

    int   n_assert = 0;
    int   n_fail   = 0;
    int   vcount   = 0;
    int   exp_ones = 0;
    bit   fresh    = 1'b1;   // no strobe seen since reset
    bit   aligned  = 1'b0;
    exp_t d1       = '{1'b0, 1'b0, 1'b0, 1'b1};

    function automatic logic rom_px(input int id, input int r, input int b);
        logic [63:0] a;
        a = art[id];
        return a[8 * (7 - r) + b];
    endfunction

    function automatic exp_t model(input bit en, input logic [8:0] e, input int h,
                                   input int v, input bit care);
        exp_t x;
        int   id, r, o, c;
        x = '{1'b0, 1'b0, 1'b0, 1'b1};
        if (en && h < 640 && v < 480) begin
            id = int'(e[5:2]);
            r  = int'(e[8:6]);
            o  = int'(e[1:0]);
            c  = (h % 40) / 5;
            x.valid = 1'b1;
            x.care  = care;
            if (id != 15) begin
                x.hit = 1'b1;
                case (o)
                    0:       x.pix = rom_px(id, r, 7 - c);
                    2:       x.pix = rom_px(id, r, c);
                    1:       x.pix = rom_px(id, c, 7 - r);
                    default: x.pix = rom_px(id, 7 - c, r);
                endcase
            end
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (H=%0d V=%0d t=%0t)",
                   tag, obs, expv, counter_H, counter_V, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs == expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: apply inputs, take the edge, then check the outputs that
    // belong to the inputs applied one step earlier.
    task automatic step(input bit rst_n_v, input bit en, input logic [8:0] e,
                        input int h, input int v);
        exp_t now;
        bit   care;
        now = '{1'b0, 1'b0, 1'b0, 1'b1};
        if (rst_n_v) begin
            care = 1'b1;
            if (en) begin
                if (fresh) begin
                    aligned = (h == 0);
                    fresh   = 1'b0;
                end
                care = aligned;
                if (h >= 639) aligned = 1'b1;
            end
            now = model(en, e, h, v, care);
            if (now.pix) exp_ones++;
        end
        reset     = rst_n_v;
        pixel_en  = en;
        entity_in = e;
        counter_H = 10'(h);
        counter_V = 10'(v);
        @(posedge clk);
        #1;
        if (!rst_n_v) begin
            check("reset_pix", pixel_out, 1'b0);
            check("reset_hit", sprite_hit, 1'b0);
            check("reset_valid", pixel_valid, 1'b0);
            d1       = '{1'b0, 1'b0, 1'b0, 1'b1};
            fresh    = 1'b1;
            exp_ones = 0;
        end else begin
            check("pixel_valid", pixel_valid, d1.valid);
            if (d1.care) begin
                check("pixel_out", pixel_out, d1.pix);
                check("sprite_hit", sprite_hit, d1.hit);
            end
            if (pixel_valid === 1'b1) vcount++;
            d1 = now;
        end
    endtask

    // Full scan line H=0..799. Either a fixed entity over the first tile with
    // 9'h1FF elsewhere, or random entities with random strobe gaps. A reset
    // pulse can replace the strobe at H=rst_at.
    task automatic run_line(input int v, input logic [8:0] e_tile, input bit rnd,
                            input int rst_at);
        logic [8:0] e;
        vcount = 0;
        for (int h = 0; h < 800; h++) begin
            e = rnd ? 9'($urandom) : ((h < 40) ? e_tile : 9'h1FF);
            if (rnd && $urandom_range(0, 4) == 0) step(1'b1, 1'b0, e, h, v);
            if (h == rst_at) step(1'b0, 1'b1, e, h, v);
            else             step(1'b1, 1'b1, e, h, v);
        end
    endtask

    initial begin
        reset     = 1'b0;
        pixel_en  = 1'b0;
        entity_in = 9'h000;
        counter_H = '0;
        counter_V = '0;

        // Reset held for three edges with a strobe present, then two quiet edges
        repeat (3) step(1'b0, 1'b1, 9'h000, 700, 10);
        repeat (2) step(1'b1, 1'b0, 9'h000, 700, 10);
        check("post_reset_pix", pixel_out, 1'b0);
        check("post_reset_valid", pixel_valid, 1'b0);

        // Empty line: no hits, exactly 640 valid pixels
        run_line(10, 9'h1FF, 1'b0, -1);
        check_int("empty_line_valid_count", vcount, 640);

        // Directed orientation sweeps over the first tile
        run_line(11, 9'h004, 1'b0, -1);   // normal: pixels 0..9 lit
        run_line(12, 9'h006, 1'b0, -1);   // mirrored: pixels 30..39 lit
        run_line(13, 9'h005, 1'b0, -1);   // transposed row 0: all lit
        run_line(14, 9'h0C5, 1'b0, -1);   // transposed row 3: none lit, all hit

        // Random lines, including lines in vertical blanking
        run_line(15, 9'h000, 1'b1, -1);
        run_line(16, 9'h000, 1'b1, -1);
        run_line(479, 9'h000, 1'b1, -1);
        run_line(480, 9'h000, 1'b1, -1);
        run_line(500, 9'h000, 1'b1, -1);

        // Mid-line reset at H=100, then a line that must be realigned
        run_line(20, 9'h000, 1'b1, 100);
        run_line(21, 9'h000, 1'b1, -1);
        run_line(22, 9'h000, 1'b1, -1);
        step(1'b1, 1'b0, 9'h1FF, 0, 23);
        step(1'b1, 1'b0, 9'h1FF, 0, 23);

`ifdef SPRITE_HIT_COUNT_EN
        begin
            int ones;
            step(1'b0, 1'b0, 9'h1FF, 700, 0);
            for (int v = 0; v < 8; v++) run_line(v, 9'h004, 1'b0, -1);
            ones = exp_ones;
            step(1'b1, 1'b1, 9'h1FF, 0, 480);   // frame-end edge
            step(1'b1, 1'b0, 9'h1FF, 0, 480);
            check_int("hit_count_model", int'(hit_count), ones);
            check_int("hit_count_80", int'(hit_count), 80);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
